regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file with an integrated busy scoreboard, for the dual-issue pipeline. It provides NR combinational read ports and NW write ports with same-cycle write-to-read forwarding, keeping register 0 hardwired to zero. A per-register busy bit is set when the decode stage reserves a destination and cleared on writeback, so issue logic reads operands and hazard status in one lookup.

---
 rtl/regfile_mp.sv | 87 ++++++++
 tb/tb_regfile_mp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; r0 is hardwired to zero, and reads forward same-cycle writes and reservations.
// Zero-cycle combinational read and busy lookup, state commits at posedge; no backpressure, every port is accepted every cycle.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int NR     = 4,
    parameter int NW     = 2,
    parameter int NRSV   = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NR*AW-1:0]       ra,
    output logic [NR*DATA_W-1:0]   rd,
    output logic [NR-1:0]          rbusy,
    input  logic [NW-1:0]          we,
    input  logic [NW*AW-1:0]       wa,
    input  logic [NW*DATA_W-1:0]   wd,
    input  logic [NRSV-1:0]        rsv_en,
    input  logic [NRSV*AW-1:0]     rsv_a,
    input  logic                   flush
);

    logic [DATA_W-1:0] r_regs [1:NREG-1];
    logic [NREG-1:1]   r_busy;

    logic [DATA_W-1:0] w_regs_nxt [0:NREG-1];
    logic [NREG-1:0]   w_busy_nxt;

    // Higher write-port index wins: later loop iterations overwrite earlier ones.
    always_comb begin
        w_regs_nxt[0] = '0;
        w_busy_nxt[0] = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            logic w_hit_w;
            logic w_hit_r;
            w_hit_w       = 1'b0;
            w_hit_r       = 1'b0;
            w_regs_nxt[r] = r_regs[r];
            for (int j = 0; j < NW; j++) begin
                if (we[j] && (wa[j*AW +: AW] == AW'(r))) begin
                    w_regs_nxt[r] = wd[j*DATA_W +: DATA_W];
                    w_hit_w       = 1'b1;
                end
            end
            for (int k = 0; k < NRSV; k++) begin
                if (rsv_en[k] && (rsv_a[k*AW +: AW] == AW'(r))) begin
                    w_hit_r = 1'b1;
                end
            end
            if (flush) begin
                w_busy_nxt[r] = 1'b0;
            end else if (w_hit_r) begin
                w_busy_nxt[r] = 1'b1;
            end else if (w_hit_w) begin
                w_busy_nxt[r] = 1'b0;
            end else begin
                w_busy_nxt[r] = r_busy[r];
            end
        end
    end

    // Slot 0 of the resolved arrays is constant zero, so r0 needs no special case here.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            rd[i*DATA_W +: DATA_W] = w_regs_nxt[ra[i*AW +: AW]];
            rbusy[i]               = w_busy_nxt[ra[i*AW +: AW]];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 1; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                r_regs[r] <= w_regs_nxt[r];
            end
            r_busy <= w_busy_nxt[NREG-1:1];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed vectors with hand-computed results, then a randomised run against a reference model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NREG = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int NRSV = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rbusy;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  wa;
    logic [NW*DW-1:0]  wd;
    logic [NRSV-1:0]   rsv_en;
    logic [NRSV*AW-1:0] rsv_a;
    logic              flush;

    logic [AW-1:0] t_ra [NR];
    logic [AW-1:0] t_wa [NW];
    logic [DW-1:0] t_wd [NW];
    logic [AW-1:0] t_ra_rsv [NRSV];

    assign ra    = {t_ra[3], t_ra[2], t_ra[1], t_ra[0]};
    assign wa    = {t_wa[1], t_wa[0]};
    assign wd    = {t_wd[1], t_wd[0]};
    assign rsv_a = {t_ra_rsv[1], t_ra_rsv[0]};

    regfile_mp #(.DATA_W(DW), .NREG(NREG), .NR(NR), .NW(NW), .NRSV(NRSV)) dut (
        .clk(clk), .resetn(resetn), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_a(rsv_a), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rb;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    total = 0;
    int    bad = 0;

    // Monitor: outputs are combinational, so each cycle with an expectation is sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (rd !== e.rd) begin
                bad++;
                $display("FAIL %s rd: got %h want %h", n, rd, e.rd);
            end
            total++;
            if (rbusy !== e.rb) begin
                bad++;
                $display("FAIL %s rbusy: got %b want %b", n, rbusy, e.rb);
            end
        end
    end

    task automatic idle();
        resetn = 1'b1;
        we = '0;
        rsv_en = '0;
        flush = 1'b0;
        for (int i = 0; i < NR; i++) t_ra[i] = '0;
        for (int j = 0; j < NW; j++) begin
            t_wa[j] = '0;
            t_wd[j] = '0;
        end
        for (int k = 0; k < NRSV; k++) t_ra_rsv[k] = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string nm, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic [3:0] rb);
        exp_t e;
        e.rd = {d3, d2, d1, d0};
        e.rb = rb;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    logic [DW-1:0] m_regs [NREG];
    logic          m_busy [NREG];

    task automatic random_cycle();
        logic [DW-1:0] nr [NREG];
        logic          nb [NREG];
        exp_t          e;
        next_cycle();
        resetn = ($urandom_range(0, 99) != 0);
        for (int i = 0; i < NR; i++)
            t_ra[i] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREG-1));
        for (int j = 0; j < NW; j++) begin
            we[j]   = ($urandom_range(0, 1) != 0);
            t_wa[j] = AW'($urandom_range(0, 7));
            t_wd[j] = $urandom();
        end
        for (int k = 0; k < NRSV; k++) begin
            rsv_en[k]   = ($urandom_range(0, 2) == 0);
            t_ra_rsv[k] = AW'($urandom_range(0, 7));
        end
        flush = ($urandom_range(0, 31) == 0);
        for (int r = 0; r < NREG; r++) begin
            nr[r] = m_regs[r];
            nb[r] = m_busy[r];
        end
        // Apply effects in ascending priority so later steps override earlier ones.
        for (int j = 0; j < NW; j++)
            if (we[j] && t_wa[j] != 0) begin
                nr[t_wa[j]] = t_wd[j];
                nb[t_wa[j]] = 1'b0;
            end
        for (int k = 0; k < NRSV; k++)
            if (rsv_en[k] && t_ra_rsv[k] != 0) nb[t_ra_rsv[k]] = 1'b1;
        if (flush)
            for (int r = 0; r < NREG; r++) nb[r] = 1'b0;
        if (resetn) begin
            for (int i = 0; i < NR; i++) begin
                e.rd[i*DW +: DW] = (t_ra[i] == 0) ? '0 : nr[t_ra[i]];
                e.rb[i]          = (t_ra[i] == 0) ? 1'b0 : nb[t_ra[i]];
            end
            exp_q.push_back(e);
            name_q.push_back("random");
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = nr[r];
                m_busy[r] = nb[r];
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;

        next_cycle();
        t_ra[0] = 5'd1; t_ra[1] = 5'd5; t_ra[2] = 5'd31;
        expect_out("reset_state", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        we[0] = 1'b1; t_wa[0] = 5'd5; t_wd[0] = 32'hDEADBEEF; t_ra[0] = 5'd5;
        expect_out("fwd_r5", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        t_ra[0] = 5'd5;
        expect_out("hold_r5", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        resetn = 1'b0;
        we[0] = 1'b1; t_wa[0] = 5'd8; t_wd[0] = 32'h1111; rsv_en[0] = 1'b1; t_ra_rsv[0] = 5'd8;

        next_cycle();
        t_ra[0] = 5'd5; t_ra[1] = 5'd8;
        expect_out("post_reset", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        we[0] = 1'b1; t_wa[0] = 5'd7; t_wd[0] = 32'h12345678; t_ra[0] = 5'd7; t_ra[1] = 5'd0;
        expect_out("fwd_zero", 32'h12345678, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        we[0] = 1'b1; t_wa[0] = 5'd0; t_wd[0] = 32'hFFFFFFFF; rsv_en[0] = 1'b1; t_ra_rsv[0] = 5'd0;
        t_ra[1] = 5'd7;
        expect_out("r0_write", 32'h0, 32'h12345678, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        t_ra[1] = 5'd7;
        expect_out("r0_after", 32'h0, 32'h12345678, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        we = 2'b11; t_wa[0] = 5'd9; t_wa[1] = 5'd9; t_wd[0] = 32'hAAAA; t_wd[1] = 32'h5555;
        t_ra[0] = 5'd9;
        expect_out("wconf", 32'h5555, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        t_ra[0] = 5'd9;
        expect_out("wconf_next", 32'h5555, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        rsv_en[0] = 1'b1; t_ra_rsv[0] = 5'd3; t_ra[0] = 5'd3; t_ra[1] = 5'd3;
        expect_out("rsv_r3", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011);

        next_cycle();
        t_ra[0] = 5'd3;
        expect_out("busy_r3", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001);

        next_cycle();
        we[1] = 1'b1; t_wa[1] = 5'd3; t_wd[1] = 32'h42; t_ra[0] = 5'd3;
        expect_out("wb_r3", 32'h42, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        t_ra[0] = 5'd3;
        expect_out("wb_r3_next", 32'h42, 32'h0, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        rsv_en[1] = 1'b1; t_ra_rsv[1] = 5'd4; we[0] = 1'b1; t_wa[0] = 5'd4; t_wd[0] = 32'hBEEF;
        t_ra[0] = 5'd4;
        expect_out("rsv_wr_r4", 32'hBEEF, 32'h0, 32'h0, 32'h0, 4'b0001);

        next_cycle();
        t_ra[0] = 5'd4;
        expect_out("rsv_wr_r4_next", 32'hBEEF, 32'h0, 32'h0, 32'h0, 4'b0001);

        next_cycle();
        flush = 1'b1; rsv_en[0] = 1'b1; t_ra_rsv[0] = 5'd6; t_ra[0] = 5'd6; t_ra[1] = 5'd4;
        expect_out("flush_rsv", 32'h0, 32'hBEEF, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        t_ra[0] = 5'd6; t_ra[1] = 5'd4;
        expect_out("flush_next", 32'h0, 32'hBEEF, 32'h0, 32'h0, 4'b0000);

        next_cycle();
        rsv_en = 2'b11; t_ra_rsv[0] = 5'd10; t_ra_rsv[1] = 5'd10;
        for (int i = 0; i < NR; i++) t_ra[i] = 5'd10;
        expect_out("dup_rsv", 32'h0, 32'h0, 32'h0, 32'h0, 4'b1111);

        next_cycle();
        we[0] = 1'b1; t_wa[0] = 5'd10; t_wd[0] = 32'h77; rsv_en[1] = 1'b1; t_ra_rsv[1] = 5'd11;
        t_ra[0] = 5'd10; t_ra[1] = 5'd11; t_ra[2] = 5'd10;
        expect_out("alias", 32'h77, 32'h0, 32'h77, 32'h0, 4'b0010);

        next_cycle();
        resetn = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        for (int c = 0; c < 10000; c++) random_cycle();

        next_cycle();
        for (int c = 0; c < 5 && exp_q.size() != 0; c++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
